// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types and constants used by the PC generator.
package rv32i_pkg;

  localparam int unsigned XLEN_DEF         = 32;
  localparam int unsigned PC_STEP          = 4;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

  typedef enum logic [1:0] {
    SEQ  = 2'b00,
    REL  = 2'b01,
    ABS  = 2'b10,
    RSVD = 2'b11
  } pc_op_t;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC candidate: sequential/relative/absolute mux plus
// alignment and reserved-op flags.
module pc_next_calc
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] offset_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] cand_c,
  output logic            misalign_c,
  output logic            illegal_c
);

  pc_op_t op_e;
  assign op_e = pc_op_t'(op_i);

  always_comb begin
    cand_c    = pc_i + XLEN'(PC_STEP);
    illegal_c = 1'b0;
    unique case (op_e)
      SEQ:  cand_c = pc_i + XLEN'(PC_STEP);
      REL:  cand_c = pc_i + offset_i;
      ABS:  cand_c = {target_i[XLEN-1:1], 1'b0};
      RSVD: begin
        cand_c    = pc_i + XLEN'(PC_STEP);
        illegal_c = 1'b1;
      end
      default: cand_c = pc_i + XLEN'(PC_STEP);
    endcase
  end

  assign misalign_c = |cand_c[1:0];

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator with BOOT/RUN sequencing and advance counter.
// Optional trap entry / MRET return with saved EPC under `PC_TRAP_EN.
module pc_gen
  import rv32i_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF,
  parameter int unsigned     CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic [XLEN-1:0]  offset,
  input  logic [XLEN-1:0]  target,
  input  logic             trap_req,
  input  logic             mret,
  output logic [XLEN-1:0]  pc,
  output logic             pc_valid,
  output logic             misalign,
  output logic             illegal_op,
  output logic [XLEN-1:0]  epc,
  output logic [CNT_W-1:0] adv_cnt
);

  pc_state_t        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             valid_q, valid_d;
  logic             mis_q, mis_d;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  epc_q, epc_d;

  logic [XLEN-1:0]  cand;
  logic             cand_mis;
  logic             cand_ill;

  pc_next_calc #(.XLEN(XLEN)) u_calc (
    .pc_i       (pc_q),
    .op_i       (op),
    .offset_i   (offset),
    .target_i   (target),
    .cand_c     (cand),
    .misalign_c (cand_mis),
    .illegal_c  (cand_ill)
  );

  // Next-state: BOOT for one edge, then RUN; ops are accepted once pc is fetchable.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = (state_q == RUN);
    mis_d   = 1'b0;
    ill_d   = 1'b0;
    cnt_d   = cnt_q;
    epc_d   = epc_q;
    if (state_q == BOOT) begin
      state_d = RUN;
    end else if (valid_q) begin
`ifdef PC_TRAP_EN
      if (trap_req) begin
        epc_d = pc_q;
        pc_d  = TRAP_VECTOR;
        mis_d = en & cand_mis;
      end else if (mret && en) begin
        pc_d = epc_q;
      end else if (en) begin
        ill_d = cand_ill;
        cnt_d = cnt_q + CNT_W'(1);
        if (cand_mis) begin
          // A misaligned target is itself a trap.
          epc_d = pc_q;
          pc_d  = TRAP_VECTOR;
          mis_d = 1'b1;
        end else begin
          pc_d = cand;
        end
      end
`else
      if (en) begin
        ill_d = cand_ill;
        if (cand_mis) begin
          mis_d = 1'b1;
        end else begin
          pc_d  = cand;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PC_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst) epc_q <= '0;
    else      epc_q <= epc_d;
  end
`else
  logic unused_trap;
  assign epc_q       = '0;
  assign unused_trap = trap_req ^ mret ^ (|epc_d);
`endif

  assign pc         = pc_q;
  assign pc_valid   = valid_q;
  assign misalign   = mis_q;
  assign illegal_op = ill_q;
  assign epc        = epc_q;
  assign adv_cnt    = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: driver queues expected post-edge state,
// monitor pops and compares on the falling edge.
module tb_pc_gen;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  typedef struct {
    string            name;
    logic [XLEN-1:0]  pc;
    logic             v;
    logic             m;
    logic             i;
    logic [XLEN-1:0]  epc;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [XLEN-1:0]  offset = '0;
  logic [XLEN-1:0]  target = '0;
  logic             trap_req = 1'b0;
  logic             mret = 1'b0;
  logic [XLEN-1:0]  pc;
  logic             pc_valid;
  logic             misalign;
  logic             illegal_op;
  logic [XLEN-1:0]  epc;
  logic [CNT_W-1:0] adv_cnt;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  pc_gen #(
    .XLEN         (XLEN),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .CNT_W        (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .op         (op),
    .offset     (offset),
    .target     (target),
    .trap_req   (trap_req),
    .mret       (mret),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .misalign   (misalign),
    .illegal_op (illegal_op),
    .epc        (epc),
    .adv_cnt    (adv_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input string fld, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h", name, fld, act, req);
    end
  endtask

  // Monitor: compare the DUT outputs after every edge that has a queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "pc",       pc,                     e.pc);
        chk(e.name, "pc_valid", XLEN'(pc_valid),        XLEN'(e.v));
        chk(e.name, "misalign", XLEN'(misalign),        XLEN'(e.m));
        chk(e.name, "illegal",  XLEN'(illegal_op),      XLEN'(e.i));
        chk(e.name, "epc",      epc,                    e.epc);
        chk(e.name, "adv_cnt",  XLEN'(adv_cnt),         XLEN'(e.cnt));
      end
    end
  end

  task automatic st(input string name, input logic r, input logic e_n, input logic [1:0] o,
                    input logic [XLEN-1:0] off, input logic [XLEN-1:0] tgt,
                    input logic tr, input logic mr,
                    input logic [XLEN-1:0] x_pc, input logic x_v, input logic x_m,
                    input logic x_i, input logic [XLEN-1:0] x_epc, input int x_cnt);
    exp_t e;
    rst = r; en = e_n; op = o; offset = off; target = tgt; trap_req = tr; mret = mr;
    @(posedge clk);
    e.name = name; e.pc = x_pc; e.v = x_v; e.m = x_m; e.i = x_i; e.epc = x_epc;
    e.cnt = CNT_W'(x_cnt);
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    logic [XLEN-1:0] ep;
    int budget;
    st("rst_a",   0, 1, 2'b00, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 0);
    st("rst_b",   0, 1, 2'b00, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 0);
    st("boot",    1, 1, 2'b00, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 0);
    st("run0",    1, 1, 2'b00, 0, 0, 0, 0, 32'h0,   1, 0, 0, 0, 0);
    st("seq4",    1, 1, 2'b00, 0, 0, 0, 0, 32'h4,   1, 0, 0, 0, 1);
    st("seq8",    1, 1, 2'b00, 0, 0, 0, 0, 32'h8,   1, 0, 0, 0, 2);
    st("abs100",  1, 1, 2'b10, 0, 32'h100, 0, 0, 32'h100, 1, 0, 0, 0, 3);
    st("rel_m8",  1, 1, 2'b01, 32'hFFFF_FFF8, 0, 0, 0, 32'hF8, 1, 0, 0, 0, 4);
    st("abs205",  1, 1, 2'b10, 0, 32'h205, 0, 0, 32'h204, 1, 0, 0, 0, 5);
    st("hold",    1, 0, 2'b01, 32'h2, 0, 0, 0, 32'h204, 1, 0, 0, 0, 5);
    st("abs10",   1, 1, 2'b10, 0, 32'h10, 0, 0, 32'h10, 1, 0, 0, 0, 6);
`ifdef PC_TRAP_EN
    st("rel6",    1, 1, 2'b01, 32'h6, 0, 0, 0, 32'h100, 1, 1, 0, 32'h10, 7);
    st("quiet",   1, 0, 2'b00, 0, 0, 0, 0, 32'h100, 1, 0, 0, 32'h10, 7);
    st("abs40",   1, 1, 2'b10, 0, 32'h40, 0, 0, 32'h40, 1, 0, 0, 32'h10, 8);
    st("trap",    1, 0, 2'b00, 0, 0, 1, 0, 32'h100, 1, 0, 0, 32'h40, 8);
    st("mret",    1, 1, 2'b00, 0, 0, 0, 1, 32'h40, 1, 0, 0, 32'h40, 8);
    ep = 32'h40;
`else
    st("rel6",    1, 1, 2'b01, 32'h6, 0, 0, 0, 32'h10, 1, 1, 0, 0, 6);
    st("quiet",   1, 0, 2'b00, 0, 0, 0, 0, 32'h10, 1, 0, 0, 0, 6);
    st("abs40",   1, 1, 2'b10, 0, 32'h40, 0, 0, 32'h40, 1, 0, 0, 0, 7);
    st("trap_ig", 1, 0, 2'b00, 0, 0, 1, 0, 32'h40, 1, 0, 0, 0, 7);
    st("mret_ig", 1, 1, 2'b00, 0, 0, 0, 1, 32'h44, 1, 0, 0, 0, 8);
    ep = 32'h0;
`endif
    st("abs_top", 1, 1, 2'b10, 0, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 0, 0, ep, 9);
    st("wrap",    1, 1, 2'b00, 0, 0, 0, 0, 32'h0, 1, 0, 0, ep, 10);
    st("rsvd",    1, 1, 2'b11, 0, 0, 0, 0, 32'h4, 1, 0, 1, ep, 11);
    st("idle",    1, 0, 2'b11, 0, 0, 0, 0, 32'h4, 1, 0, 0, ep, 11);
    for (int k = 0; k < 5; k++)
      st("cntwrap", 1, 1, 2'b00, 0, 0, 0, 0, 32'h8 + XLEN'(4 * k), 1, 0, 0, ep, (12 + k) % 16);
    st("rst_trap", 0, 1, 2'b00, 0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0);
    st("reboot",  1, 0, 2'b00, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0);

    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RV32I core, successor to the single-mode PC register. Holds the architectural PC and computes the next PC for sequential, PC-relative (branch/JAL) and absolute (JALR) flow. It also detects misaligned targets, counts accepted advances and, optionally, handles trap entry and MRET return with a saved EPC. It sits between the decode/branch unit (op, offset, target) and the instruction-memory address port.

## Interface

Parameters:
- `XLEN`, 32, PC and operand width.
- `RESET_VECTOR`, 32'h0000_0000, PC value loaded on reset.
- `TRAP_VECTOR`, 32'h0000_0100, PC loaded on trap entry. Used only with `PC_TRAP_EN`.
- `CNT_W`, 16, width of the advance counter.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `en` in 1: advance enable; when low, PC holds.
- `op` in 2: 00 SEQ, 01 REL, 10 ABS, 11 reserved.
- `offset` in XLEN: signed byte offset for REL.
- `target` in XLEN: absolute target for ABS.
- `trap_req` in 1: trap request (`PC_TRAP_EN` only).
- `mret` in 1: return from trap (`PC_TRAP_EN` only).
- `pc` out XLEN: current PC.
- `pc_valid` out 1: `pc` is fetchable.
- `misalign` out 1: one-cycle pulse, rejected misaligned target.
- `illegal_op` out 1: one-cycle pulse, reserved op accepted.
- `epc` out XLEN: saved exception PC (`PC_TRAP_EN` only, else tied 0).
- `adv_cnt` out CNT_W: accepted-advance counter.

## Operation

- FSM has two states, BOOT and RUN.
  - Reset forces BOOT.
  - BOOT -> RUN unconditionally on the next edge.
  - `pc_valid` = (state == RUN).
  - In BOOT, all inputs are ignored.
- Candidate next PC in RUN when `en`=1:
  - SEQ: `pc + 4`.
  - REL: `pc + offset`, two's complement, wraps modulo 2^XLEN.
  - ABS: `target` with bit 0 cleared.
  - Reserved (11): treated as SEQ, and `illegal_op` pulses.
- Alignment check applies to the candidate only:
  - If candidate[1:0] == 2'b00, `pc` takes the candidate and `adv_cnt` increments.
  - Otherwise `pc` holds and `misalign` pulses. Without `PC_TRAP_EN`, `adv_cnt` does not increment.
- `adv_cnt` wraps at 2^CNT_W − 1 -> 0.
- Priority, highest first:
  1. `rst` low
  2. BOOT
  3. `trap_req`
  4. `mret`
  5. `en` op
- `en`=0 with no trap: `pc`, `epc` and `adv_cnt` hold, and no pulses are generated.

## Timing

- Reset values:
  - `pc` = RESET_VECTOR
  - `pc_valid` = 0
  - `misalign` = 0
  - `illegal_op` = 0
  - `epc` = 0
  - `adv_cnt` = 0
  - state = BOOT
- `pc_valid` rises on the second edge after `rst` returns high.
- All outputs are registered. Next-PC latency is 1 cycle: the candidate presented in cycle N appears on `pc` in cycle N+1.
- `misalign` and `illegal_op` are high for exactly the cycle after the offending edge.
- Reset asserted mid-operation overrides everything on that edge, including a trap in progress. No partial update survives.
- `trap_req` and `mret` are sampled only in RUN. `trap_req` does not require `en`; `mret` requires `en`=1.

## Configuration

- `PC_TRAP_EN` defined:
  - `trap_req` loads `epc` <= `pc` and `pc` <= TRAP_VECTOR.
  - `mret` with `en` loads `pc` <= `epc`.
  - A misaligned candidate is itself a trap: `epc` <= `pc`, `pc` <= TRAP_VECTOR, and `misalign` still pulses.
  - If `trap_req` and a misaligned candidate occur on the same edge, a single trap is taken, `epc` = `pc`, and `misalign` pulses.
  - If `trap_req` and `mret` occur together, the trap wins.
- `PC_TRAP_EN` undefined:
  - `trap_req` and `mret` are ignored.
  - `epc` is a constant 0 with no register.
  - A misaligned candidate only holds `pc` and pulses `misalign`.

## Structure

- Shared package `rv32i_pkg`:
  - `pc_op_t` enum: SEQ, REL, ABS, RSVD.
  - `pc_state_t` enum: BOOT, RUN.
  - Constants `PC_STEP` = 4 and the default vectors.
- One sub-module, `pc_next_calc`: a combinational candidate adder/mux plus alignment check, outputting the candidate, misaligned flag and illegal flag.
- All registers (PC, FSM, EPC, counter) stay in `pc_gen`.

## Test plan

1. Reset, then release `rst` with `en`=1, op=SEQ -> cycle 1: `pc`=0, `pc_valid`=0; cycle 2: `pc_valid`=1; then `pc` steps 0, 4, 8; `adv_cnt`=2 after two advances.
2. `pc`=0x100, op=REL, `offset`=−8 -> `pc`=0xF8. Then op=ABS, `target`=0x205 -> `pc`=0x204.
3. `pc`=0x10, op=REL, `offset`=6 -> without the macro: `pc` stays 0x10, `misalign` high one cycle, `adv_cnt` unchanged. With `PC_TRAP_EN`: `pc`=0x100, `epc`=0x10.
4. `PC_TRAP_EN`: `pc`=0x40, `trap_req`=1 with `en`=0 -> `pc`=0x100, `epc`=0x40. Then `mret` with `en`=1 -> `pc`=0x40.
5. `pc`=0xFFFF_FFFC, op=SEQ -> `pc`=0 (wrap). `op`=11 -> `pc`+4 and `illegal_op` pulses. `rst` low during a trap edge -> `pc`=RESET_VECTOR, `epc`=0.
